gate_vector_sequencer: RTL
==========================

// Module: gate_vector_sequencer
// PURPOSE
//   Drives an N-input combinational gate under test with every input combination in turn.
//   Holds each vector for HOLD cycles, then samples the gate output and checks it against a
//   golden model of the selected gate function. Reports pass/fail and done to a controller.
//   Sits directly upstream of the gate; also consumes the gate's output for checking.
// PARAMETERS
//   N_IN     2       gate input count; vectors 0 .. 2**N_IN-1; legal 1..8
//   HOLD     10      cycles each vector is driven; legal >=1
//   GATE_OP  OP_AND  golden function (gate_seq_pkg::gate_op_e: OP_AND/OR/XOR/NAND/NOR/XNOR)
//   CNT_W    8       error counter width (only with GATE_SEQ_ERRCNT_EN)
// PORTS
//   clk       in   1      clock, rising edge
//   rst_n     in   1      reset, asynchronous, active-low
//   start     in   1      begin a sweep; sampled only in IDLE
//   in_vec    out  N_IN   drives gate inputs; in_vec[0]=in_a, in_vec[1]=in_b
//   gate_out  in   1      gate response
//   busy      out  1      high from the cycle after start through the DONE cycle
//   mismatch  out  1      one-cycle pulse, previous sample != golden
//   done      out  1      one-cycle pulse at end of sweep
//   pass      out  1      1 = no mismatch in the last sweep; held until next start
//   err_cnt   out  CNT_W  mismatch count (GATE_SEQ_ERRCNT_EN only)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; in_vec, busy, mismatch, done, pass, err_cnt, hold_cnt=0.
//   FSM states: IDLE, DRIVE, DONE.
//   IDLE:  start=1 at edge -> DRIVE, in_vec=0, hold_cnt=0, pass=1, err_cnt=0.
//   DRIVE: hold_cnt increments each cycle. At the edge where hold_cnt==HOLD-1:
//          - mismatch<=(gate_out != golden(in_vec)).
//          - On mismatch, pass<=0 and err_cnt++ (saturates at all-ones).
//          - If in_vec==2**N_IN-1 -> DONE, in_vec held; else in_vec++, hold_cnt=0.
//   DONE:  done=1 for exactly one cycle -> IDLE; in_vec returns to 0 on that exit edge.
//   Sweep timing: start edge + 2**N_IN*HOLD DRIVE cycles + 1 DONE cycle.
//   Last mismatch pulse coincides with the done cycle. pass and err_cnt are final when done=1.
//   start while busy: ignored, no restart.
//   start held high in IDLE after DONE: a new sweep begins (back-to-back allowed).
//   HOLD=1: a new vector every cycle; sample taken the same cycle each vector is driven.
//   Golden value and compare are purely combinational on in_vec; gate_out is sampled raw.
//   gate_out is assumed synchronous to clk.
//   Reset mid-sweep: immediate abort, all outputs 0; no done pulse.
//   hold_cnt width = $clog2(HOLD+1); vector counter width = N_IN+1 internally, no wrap.
// CONFIGURATION
//   GATE_SEQ_ERRCNT_EN defined: err_cnt port and saturating CNT_W counter present,
//     cleared on start.
//   Not defined: err_cnt port and counter absent; pass/mismatch unchanged.
// STRUCTURE
//   gate_seq_pkg: gate_op_e enum, seq_state_e enum (IDLE/DRIVE/DONE),
//     function golden(op, vec) returning 1 bit.
//   One sub-module: gate_golden_model (combinational, GATE_OP param) wrapping golden();
//     FSM and counters stay in gate_vector_sequencer.
// TESTING  (N_IN=2, HOLD=10, GATE_OP=OP_AND unless stated; bench drives gate_out from a model)
//   1. Correct AND, start pulse -> in_vec 00,01,10,11 for 10 cycles each;
//      done 41 cycles after start edge; pass=1, err_cnt=0, no mismatch.
//   2. gate_out stuck 0 -> single mismatch pulse after vector 11; done with pass=0, err_cnt=1.
//   3. gate_out stuck 1 -> mismatch after vectors 00,01,10; pass=0, err_cnt=3.
//   4. start re-pulsed at cycle 15 of a sweep -> ignored; sweep length and results identical to 1.
//   5. rst_n low while in_vec=10 -> same-cycle outputs 0, IDLE; then start -> clean full sweep.
//   6. N_IN=3, HOLD=1, OP_XOR, correct gate -> in_vec 0..7 on consecutive cycles;
//      done at cycle 9, pass=1.

Source files
------------

// File: rtl/gate_vector_sequencer_pkg.sv
// gate_seq_pkg: gate function and sequencer state enums plus the golden gate function.
package gate_seq_pkg;
   typedef enum logic [2:0] {OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR} gate_op_e;
   typedef enum logic [1:0] {IDLE, DRIVE, DONE} seq_state_e;
   // Only the low n bits of vec are gate inputs; the rest are masked out.
   function automatic logic golden(gate_op_e op, logic [7:0] vec, int n);
      logic [7:0] m;
      logic a, o, x;
      m = 8'hFF >> (8 - n);
      a = &(vec | ~m);
      o = |(vec & m);
      x = ^(vec & m);
      return (op == OP_AND) ? a : (op == OP_OR) ? o : (op == OP_XOR) ? x :
             (op == OP_NAND) ? !a : (op == OP_NOR) ? !o : !x;
   endfunction
endpackage

// File: rtl/gate_vector_sequencer_golden.sv
// gate_golden_model: combinational reference value of GATE_OP for the current vector.
module gate_golden_model
   import gate_seq_pkg::*;
#(
   parameter int       N_IN    = 2,
   parameter gate_op_e GATE_OP = OP_AND
) (
   input  logic [N_IN-1:0] i_vec,
   output logic            o_golden
);
   assign o_golden = golden(GATE_OP, 8'(i_vec), N_IN);
endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: sweeps all gate input vectors, holds each HOLD cycles and checks the gate.
// GATE_SEQ_ERRCNT_EN adds a saturating mismatch counter on o_err_cnt.
module gate_vector_sequencer
   import gate_seq_pkg::*;
#(
   parameter int       N_IN    = 2,
   parameter int       HOLD    = 10,
   parameter gate_op_e GATE_OP = OP_AND
`ifdef GATE_SEQ_ERRCNT_EN
   , parameter int     CNT_W   = 8
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   output logic [N_IN-1:0] o_in_vec,
   input  logic            i_gate_out,
   output logic            o_busy,
   output logic            o_mismatch,
   output logic            o_done,
   output logic            o_pass
`ifdef GATE_SEQ_ERRCNT_EN
   , output logic [CNT_W-1:0] o_err_cnt
`endif
);
   localparam int HW = $clog2(HOLD + 1);
   localparam int VW = N_IN + 1;
   seq_state_e    r_state, w_next;
   logic [HW-1:0] r_hold;
   logic [VW-1:0] r_vec;
   logic          r_mismatch, r_pass;
   logic          w_golden, w_sample, w_last, w_bad, w_go;
`ifdef GATE_SEQ_ERRCNT_EN
   logic [CNT_W-1:0] r_err;
   assign o_err_cnt = r_err;
`endif
   gate_golden_model #(.N_IN(N_IN), .GATE_OP(GATE_OP)) u_golden (
      .i_vec    (r_vec[N_IN-1:0]),
      .o_golden (w_golden)
   );
   assign w_go     = (r_state == IDLE) && i_start;
   assign w_sample = (r_state == DRIVE) && (r_hold == HW'(HOLD - 1));
   assign w_last   = r_vec == VW'(2 ** N_IN - 1);
   assign w_bad    = i_gate_out != w_golden;
   always_comb begin
      w_next = r_state;
      w_next = w_go ? DRIVE : (w_sample && w_last) ? DONE : (r_state == DONE) ? IDLE : r_state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_hold     <= '0;
         r_vec      <= '0;
         r_mismatch <= 1'b0;
         r_pass     <= 1'b0;
`ifdef GATE_SEQ_ERRCNT_EN
         r_err      <= '0;
`endif
      end else begin
         r_state    <= w_next;
         r_mismatch <= w_sample && w_bad;
         if (w_go) begin
            r_vec  <= '0;
            r_hold <= '0;
            r_pass <= 1'b1;
`ifdef GATE_SEQ_ERRCNT_EN
            r_err  <= '0;
`endif
         end else if (r_state == DRIVE) begin
            if (w_sample) begin
               if (w_bad) begin
                  r_pass <= 1'b0;
`ifdef GATE_SEQ_ERRCNT_EN
                  if (r_err != '1) r_err <= r_err + 1'b1;
`endif
               end
               // Final vector stays on the gate through the DONE cycle.
               if (!w_last) begin
                  r_vec  <= r_vec + 1'b1;
                  r_hold <= '0;
               end
            end else
               r_hold <= r_hold + 1'b1;
         end else if (r_state == DONE)
            r_vec <= '0;
      end
   end
   assign o_in_vec   = r_vec[N_IN-1:0];
   assign o_busy     = r_state != IDLE;
   assign o_done     = r_state == DONE;
   assign o_mismatch = r_mismatch;
   assign o_pass     = r_pass;
endmodule
